request_unit: RTL and testbench

Sequencing block between the control unit and the memory arbiter in the single-cycle datapath. It consumes the decoded control strobes (DatRead, DatWrite, Halt) for the instruction currently returned by instruction memory. It issues instruction-fetch and data-memory requests, holds each request until the matching hit, and gates PC advance. It latches a terminal halt state and keeps a saturating memory-stall counter for performance observation.

---
 rtl/request_unit_pkg.sv | 7 +
 rtl/request_unit_if.sv | 23 ++
 rtl/sat_counter.sv | 14 +
 rtl/request_unit.sv | 82 ++++++++
 tb/tb_request_unit.sv | 133 +++++++++++++
 5 files changed

// File: rtl/request_unit_pkg.sv
// request_unit_pkg: shared types for the fetch/data request sequencer
package request_unit_pkg;
  typedef enum logic [1:0] {FETCH, DATA, HALTED} reqstate_t;
  function automatic logic is_mem(input logic rd, input logic wr);
    return rd | wr;
  endfunction
endpackage

// File: rtl/request_unit_if.sv
// request_unit_if: bundle between the request sequencer and the datapath
interface request_unit_if #(parameter int STALL_W = 16);
  logic DatRead;
  logic DatWrite;
  logic Halt;
  logic ihit;
  logic dhit;
  logic imemREN;
  logic dmemREN;
  logic dmemWEN;
  logic pcEn;
  logic halt;
  logic err;
  logic [STALL_W-1:0] stallCount;
  modport ru (
    input  DatRead, DatWrite, Halt, ihit, dhit,
    output imemREN, dmemREN, dmemWEN, pcEn, halt, err, stallCount
  );
  modport dp (
    output DatRead, DatWrite, Halt, ihit, dhit,
    input  imemREN, dmemREN, dmemWEN, pcEn, halt, err, stallCount
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up counter with enable and sync clear that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = rst ? '0 : (en && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/request_unit.sv
// request_unit: issues fetch/data requests, gates PC advance, tracks halt/err/stalls
module request_unit
  import request_unit_pkg::*;
#(
  parameter int STALL_W = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               DatRead,
  input  logic               DatWrite,
  input  logic               Halt,
  input  logic               ihit,
  input  logic               dhit,
  output logic               imemREN,
  output logic               dmemREN,
  output logic               dmemWEN,
  output logic               pcEn,
  output logic               halt,
  output logic               err,
  output logic [STALL_W-1:0] stallCount
);
  reqstate_t state_q, state_d;
  logic rd_q, rd_d, wr_q, wr_d, halt_q, halt_d, err_q, err_d, pc_en, stall_en;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    halt_d  = halt_q;
    err_d   = err_q;
    pc_en   = 1'b0;
    if (RST) begin
      state_d = FETCH;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      halt_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        FETCH: if (ihit) begin
          err_d = err_q | (DatRead & DatWrite);
          if (Halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (is_mem(DatRead, DatWrite)) begin
            // a conflicting read+write is carried out as a write
            state_d = DATA;
            rd_d    = DatRead & ~DatWrite;
            wr_d    = DatWrite;
          end else pc_en = 1'b1;
        end
        DATA: if (dhit) begin
          state_d = FETCH;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          pc_en   = 1'b1;
        end
        HALTED: ;
        default: state_d = FETCH;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    state_q <= state_d;
    rd_q    <= rd_d;
    wr_q    <= wr_d;
    halt_q  <= halt_d;
    err_q   <= err_d;
  end
  assign imemREN  = ~RST & (state_q == FETCH);
  assign dmemREN  = ~RST & (state_q == DATA) & rd_q;
  assign dmemWEN  = ~RST & (state_q == DATA) & wr_q;
  assign pcEn     = pc_en;
  assign halt     = halt_q;
  assign err      = err_q;
  assign stall_en = ~RST & (((state_q == FETCH) & ~ihit) | ((state_q == DATA) & ~dhit));
  sat_counter #(.W(STALL_W)) u_stall (
    .clk  (CLK),
    .rst  (RST),
    .en   (stall_en),
    .count(stallCount)
  );
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: vector-table check of request_unit plus a saturation run on a narrow instance
module tb_request_unit;
  logic clk = 1'b0;
  logic rst, dat_read, dat_write, hlt, ihit, dhit;
  logic imem_ren, dmem_ren, dmem_wen, pc_en, halt, err;
  logic [15:0] stall16;
  logic imem_ren3, dmem_ren3, dmem_wen3, pc_en3, halt3, err3;
  logic [2:0] stall3;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  request_unit #(.STALL_W(16)) dut (
    .CLK(clk), .RST(rst), .DatRead(dat_read), .DatWrite(dat_write), .Halt(hlt),
    .ihit(ihit), .dhit(dhit), .imemREN(imem_ren), .dmemREN(dmem_ren), .dmemWEN(dmem_wen),
    .pcEn(pc_en), .halt(halt), .err(err), .stallCount(stall16)
  );

  request_unit #(.STALL_W(3)) dut3 (
    .CLK(clk), .RST(rst), .DatRead(dat_read), .DatWrite(dat_write), .Halt(hlt),
    .ihit(ihit), .dhit(dhit), .imemREN(imem_ren3), .dmemREN(dmem_ren3), .dmemWEN(dmem_wen3),
    .pcEn(pc_en3), .halt(halt3), .err(err3), .stallCount(stall3)
  );

  // inputs: {rst, DatRead, DatWrite, Halt, ihit, dhit}
  // outputs: {imemREN, dmemREN, dmemWEN, pcEn, halt, err}
  typedef struct {
    logic [5:0]  in;
    logic [5:0]  exp;
    logic [15:0] sc;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(input logic [5:0] in, input logic [5:0] exp, input int sc);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    v.sc  = 16'(sc);
    return v;
  endfunction

  task automatic drive(input logic [5:0] in);
    {rst, dat_read, dat_write, hlt, ihit, dhit} = in;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vq.push_back(mk(6'b100000, 6'b000000, 0)); // reset
    vq.push_back(mk(6'b100000, 6'b000000, 0));
    vq.push_back(mk(6'b000000, 6'b100000, 0)); // idle, strobes without ihit ignored
    vq.push_back(mk(6'b010100, 6'b100000, 1));
    vq.push_back(mk(6'b000000, 6'b100000, 2));
    vq.push_back(mk(6'b000000, 6'b100000, 3));
    vq.push_back(mk(6'b000000, 6'b100000, 4));
    vq.push_back(mk(6'b000010, 6'b100100, 5)); // ALU stream
    vq.push_back(mk(6'b000010, 6'b100100, 5));
    vq.push_back(mk(6'b000010, 6'b100100, 5));
    vq.push_back(mk(6'b000010, 6'b100100, 5));
    vq.push_back(mk(6'b010010, 6'b100000, 5)); // load, 3 data cycles
    vq.push_back(mk(6'b000000, 6'b010000, 5));
    vq.push_back(mk(6'b000000, 6'b010000, 6));
    vq.push_back(mk(6'b000001, 6'b010100, 7));
    vq.push_back(mk(6'b000000, 6'b100000, 7));
    vq.push_back(mk(6'b011010, 6'b100000, 8)); // conflicting strobes
    vq.push_back(mk(6'b000001, 6'b001101, 8));
    vq.push_back(mk(6'b000010, 6'b100101, 8));
    vq.push_back(mk(6'b000010, 6'b100101, 8));
    vq.push_back(mk(6'b001110, 6'b100001, 8)); // halt beats DatWrite
    vq.push_back(mk(6'b000011, 6'b000011, 8));
    vq.push_back(mk(6'b010010, 6'b000011, 8));
    vq.push_back(mk(6'b000000, 6'b000011, 8));
    vq.push_back(mk(6'b100000, 6'b000011, 8)); // reset leaves halt
    vq.push_back(mk(6'b000000, 6'b100000, 0));
    vq.push_back(mk(6'b010010, 6'b100000, 1)); // reset in DATA
    vq.push_back(mk(6'b000000, 6'b010000, 1));
    vq.push_back(mk(6'b100000, 6'b000000, 2));
    vq.push_back(mk(6'b000001, 6'b100000, 0));
    vq.push_back(mk(6'b000000, 6'b100000, 1));

    drive(6'b100000);
    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].in);
      @(negedge clk);
      chk($sformatf("vec%0d outs", i),
          16'({imem_ren, dmem_ren, dmem_wen, pc_en, halt, err}), 16'(vq[i].exp));
      chk($sformatf("vec%0d stall", i), stall16, vq[i].sc);
      @(posedge clk); #1;
    end

    // write held across several DATA cycles until dhit
    drive(6'b001010);
    @(posedge clk); #1;
    drive(6'b000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("wr_hold%0d", i), 16'({imem_ren, dmem_ren, dmem_wen, pc_en}), 16'b0010);
      @(posedge clk); #1;
    end
    drive(6'b000001);
    @(negedge clk);
    chk("wr_dhit", 16'({imem_ren, dmem_ren, dmem_wen, pc_en}), 16'b0011);
    @(posedge clk); #1;
    drive(6'b000010);
    @(negedge clk);
    chk("wr_after", 16'({imem_ren, dmem_ren, dmem_wen, pc_en}), 16'b1001);

    // saturation on the 3-bit counter
    @(posedge clk); #1;
    drive(6'b100000);
    @(posedge clk); #1;
    drive(6'b000000);
    repeat (10) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("sat3", 16'(stall3), 16'd7);
    chk("wide10", stall16, 16'd10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat3_hold", 16'(stall3), 16'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
